// File: rtl/pixel_frame_ctrl_pkg.sv
// PixelSensorConfig: shared configuration for the pixel frame sequencer.
// Holds the array width, default timing constants, the phase and readout
// state enums, the row bus type and small helpers used by the RTL.
package PixelSensorConfig;

    localparam int PIXEL_ARRAY_WIDTH = 4;

    localparam int DEF_ROWS      = 4;
    localparam int DEF_C_ERASE   = 5;
    localparam int DEF_C_CONVERT = 255;
    localparam int DEF_C_SETTLE  = 2;

    typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ} frame_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_SETTLE, RD_WAIT} rd_state_t;

    typedef logic [PIXEL_ARRAY_WIDTH-1:0][7:0] row_t;

    // Both FSM states, exported together for observation.
    typedef struct packed {
        frame_state_t frame;
        rd_state_t    rd;
    } dbg_state_t;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A zero exposure request still exposes for one cycle.
    function automatic logic [7:0] clamp_exposure(input logic [7:0] cycles);
        return (cycles == 8'd0) ? 8'd1 : cycles;
    endfunction

endpackage

// File: rtl/pixel_frame_ctrl_if.sv
// pixel_frame_ctrl_if: row output stream of the frame sequencer.
//   out_valid  master->slave  out_data/out_row hold a captured row
//   out_ready  slave->master  consumer accepts the current row
//   out_data   master->slave  captured row, COLS bytes
//   out_row    master->slave  index of the captured row
// Handshake: a row transfers on a rising edge where out_valid and out_ready
// are both 1. Once out_valid rises, out_data and out_row stay stable until
// that transfer; out_valid never drops without a transfer, and out_ready may
// change freely in any cycle.
interface pixel_frame_ctrl_if
    import PixelSensorConfig::*;
#(
    parameter int COLS  = PIXEL_ARRAY_WIDTH,
    parameter int ROW_W = 2
) ();
    logic                 out_valid;
    logic                 out_ready;
    logic [COLS-1:0][7:0] out_data;
    logic [ROW_W-1:0]     out_row;

    modport master (output out_valid, output out_data, output out_row, input out_ready);
    modport slave  (input out_valid, input out_data, input out_row, output out_ready);
endinterface

// File: rtl/pixel_frame_ctrl_row_readout.sv
// pixel_frame_ctrl_row_readout: READ phase of the frame sequencer.
// Walks rows 0..ROWS-1: drives read_row one-hot for C_SETTLE cycles, captures
// the row bus on the last settle cycle, then offers the row on out_if until
// accepted.
//   clk, reset  clock, asynchronous active-low reset
//   rd_start    single-cycle pulse, begin with row 0 (ignored unless idle)
//   rd_done     combinational pulse: last row is being accepted this edge
//   read_row    registered one-hot row read enable
//   row_data    shared row bus from the selected row
//   rd_state    current readout state
//   out_if      row output stream (master side)
module pixel_frame_ctrl_row_readout
    import PixelSensorConfig::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = PIXEL_ARRAY_WIDTH,
    parameter int C_SETTLE = DEF_C_SETTLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_start,
    output logic                 rd_done,
    output logic [ROWS-1:0]      read_row,
    input  logic [COLS-1:0][7:0] row_data,
    output rd_state_t            rd_state,
    pixel_frame_ctrl_if.master   out_if
);
    localparam int ROW_W = idx_width(ROWS);
    localparam int SET_W = idx_width(C_SETTLE + 1);
    localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(ROWS - 1);
    localparam logic [SET_W-1:0] LAST_SETTLE = SET_W'(C_SETTLE - 1);

    rd_state_t            state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [SET_W-1:0]     scnt_q, scnt_d;
    logic [ROWS-1:0]      read_row_q, read_row_d;
    logic                 valid_q, valid_d;
    logic [COLS-1:0][7:0] data_q, data_d;
    logic [ROW_W-1:0]     orow_q, orow_d;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        scnt_d     = scnt_q;
        read_row_d = '0;
        valid_d    = valid_q;
        data_d     = data_q;
        orow_d     = orow_q;
        rd_done    = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (rd_start) begin
                    state_d    = RD_SETTLE;
                    row_d      = '0;
                    scnt_d     = '0;
                    read_row_d = ROWS'(1);
                end
            end
            RD_SETTLE: begin
                if (scnt_q == LAST_SETTLE) begin
                    // The row has settled for C_SETTLE cycles: sample it and
                    // release the row enable in the same edge.
                    state_d = RD_WAIT;
                    valid_d = 1'b1;
                    data_d  = row_data;
                    orow_d  = row_q;
                end else begin
                    scnt_d     = scnt_q + 1'b1;
                    read_row_d = ROWS'(1) << row_q;
                end
            end
            RD_WAIT: begin
                // valid_q is 1 throughout this state.
                if (out_if.out_ready) begin
                    valid_d = 1'b0;
                    if (row_q == LAST_ROW) begin
                        state_d = RD_IDLE;
                        rd_done = 1'b1;
                    end else begin
                        state_d    = RD_SETTLE;
                        row_d      = row_q + 1'b1;
                        scnt_d     = '0;
                        read_row_d = ROWS'(1) << (row_q + 1'b1);
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RD_IDLE;
            row_q      <= '0;
            scnt_q     <= '0;
            read_row_q <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            orow_q     <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            scnt_q     <= scnt_d;
            read_row_q <= read_row_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            orow_q     <= orow_d;
        end
    end

    assign read_row         = read_row_q;
    assign rd_state         = state_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_row   = orow_q;
endmodule

// File: rtl/pixel_frame_ctrl.sv
// pixel_frame_ctrl: frame sequencer for a ROWS x COLS pixel array.
// Runs erase -> expose -> convert (with ADC ramp) -> row readout, single-shot
// or continuous. Every output is a flop loaded from next-state decode.
//   clk, reset       clock, asynchronous active-low reset
//   start            begin a frame (IDLE only)
//   continuous       repeat frames after readout (sampled at start)
//   stop             cancel a pending continuous run
//   exposure_cycles  exposure length, 0 behaves as 1 (sampled per frame)
//   erase/expose/convert  phase strobes
//   adc_count        ramp value during convert, else 0
//   read_row         one-hot row enable
//   row_data         shared row bus
//   out_if           row output stream (master)
//   busy             not IDLE
//   frame_done       one-cycle pulse after the last row is accepted
//   dbg_state        frame and readout FSM states
module pixel_frame_ctrl
    import PixelSensorConfig::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = PIXEL_ARRAY_WIDTH,
    parameter int C_ERASE   = DEF_C_ERASE,
    parameter int C_CONVERT = DEF_C_CONVERT,
    parameter int C_SETTLE  = DEF_C_SETTLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 stop,
    input  logic [7:0]           exposure_cycles,
    output logic                 erase,
    output logic                 expose,
    output logic                 convert,
    output logic [7:0]           adc_count,
    output logic [ROWS-1:0]      read_row,
    input  logic [COLS-1:0][7:0] row_data,
    pixel_frame_ctrl_if.master   out_if,
    output logic                 busy,
    output logic                 frame_done,
    output dbg_state_t           dbg_state
);
    // One shared phase counter; it must reach C_ERASE-1 and 255.
    localparam int CNT_W = (C_ERASE > 256) ? $clog2(C_ERASE) : 8;
    localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(C_ERASE - 1);
    localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(C_CONVERT);

    frame_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       exp_len_q, exp_len_d;
    logic             run_q, run_d;
    logic             erase_q, erase_d;
    logic             expose_q, expose_d;
    logic             convert_q, convert_d;
    logic [7:0]       adc_q, adc_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic [7:0]       exp_last;
    logic             rd_start;
    logic             rd_done;
    rd_state_t        rd_state;

    assign exp_last = exp_len_q - 8'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        exp_len_d    = exp_len_q;
        run_d        = run_q;
        rd_start     = 1'b0;
        frame_done_d = 1'b0;
        if (state_q != IDLE && stop) begin
            run_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ERASE;
                    cnt_d     = '0;
                    exp_len_d = clamp_exposure(exposure_cycles);
                    run_d     = continuous & ~stop;
                end
            end
            ERASE: begin
                if (cnt_q == ERASE_LAST) begin
                    state_d = EXPOSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EXPOSE: begin
                if (cnt_q == CNT_W'(exp_last)) begin
                    state_d = CONVERT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CONVERT: begin
                if (cnt_q == CONV_LAST) begin
                    state_d  = READ;
                    cnt_d    = '0;
                    rd_start = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READ: begin
                if (rd_done) begin
                    frame_done_d = 1'b1;
                    // stop in this very cycle still cancels the restart.
                    if (run_q && !stop) begin
                        state_d   = ERASE;
                        cnt_d     = '0;
                        exp_len_d = clamp_exposure(exposure_cycles);
                    end else begin
                        state_d = IDLE;
                        run_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        erase_d   = (state_d == ERASE);
        expose_d  = (state_d == EXPOSE);
        convert_d = (state_d == CONVERT);
        adc_d     = (state_d == CONVERT) ? cnt_d[7:0] : 8'd0;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            exp_len_q    <= '0;
            run_q        <= 1'b0;
            erase_q      <= 1'b0;
            expose_q     <= 1'b0;
            convert_q    <= 1'b0;
            adc_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            exp_len_q    <= exp_len_d;
            run_q        <= run_d;
            erase_q      <= erase_d;
            expose_q     <= expose_d;
            convert_q    <= convert_d;
            adc_q        <= adc_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    pixel_frame_ctrl_row_readout #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .C_SETTLE (C_SETTLE)
    ) u_row_readout (
        .clk      (clk),
        .reset    (reset),
        .rd_start (rd_start),
        .rd_done  (rd_done),
        .read_row (read_row),
        .row_data (row_data),
        .rd_state (rd_state),
        .out_if   (out_if)
    );

    assign erase      = erase_q;
    assign expose     = expose_q;
    assign convert    = convert_q;
    assign adc_count  = adc_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = '{frame: state_q, rd: rd_state};
endmodule

// File: tb/tb_pixel_frame_ctrl.sv
module tb_pixel_frame_ctrl;
    import PixelSensorConfig::*;

    localparam int ROWS      = 4;
    localparam int COLS      = PIXEL_ARRAY_WIDTH;
    localparam int C_ERASE   = 5;
    localparam int C_CONVERT = 255;
    localparam int C_SETTLE  = 2;
    localparam int ROW_W     = 2;
    localparam int W         = ROW_W + COLS * 8;
    localparam int BUDGET    = 3000;

    // ---------------- clock / reset / signals ----------------
    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic                 continuous = 1'b0;
    logic                 stop = 1'b0;
    logic [7:0]           exposure_cycles = 8'd0;
    logic                 erase, expose, convert, busy, frame_done;
    logic [7:0]           adc_count;
    logic [ROWS-1:0]      read_row;
    logic [COLS-1:0][7:0] row_data;
    dbg_state_t           dbg_state;

    pixel_frame_ctrl_if #(.COLS(COLS), .ROW_W(ROW_W)) out_if ();

    pixel_frame_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .C_ERASE(C_ERASE),
        .C_CONVERT(C_CONVERT), .C_SETTLE(C_SETTLE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .stop(stop), .exposure_cycles(exposure_cycles), .erase(erase),
        .expose(expose), .convert(convert), .adc_count(adc_count),
        .read_row(read_row), .row_data(row_data), .out_if(out_if),
        .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Pixel array stub: selected row r drives 8'h10*r + col.
    always_comb begin
        row_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (read_row[r]) begin
                for (int c = 0; c < COLS; c++) row_data[c] = 8'(16 * r + c);
            end
        end
    end

    function automatic logic [W-1:0] row_word(input int r);
        logic [COLS-1:0][7:0] d;
        for (int c = 0; c < COLS; c++) d[c] = 8'(16 * r + c);
        return {ROW_W'(r), d};
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({erase, expose, convert, adc_count, read_row, out_if.out_valid,
                    out_if.out_data, out_if.out_row, busy, frame_done});
    endfunction

    // ---------------- scoreboard / monitor ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    int erase_run = 0, expose_run = 0, convert_run = 0;
    int erase_lens[$], expose_lens[$], convert_lens[$];
    int done_cnt = 0, adc_errs = 0, overlap_errs = 0;
    logic [7:0] adc_exp = 8'd0;

    always @(negedge clk) begin
        if (erase) erase_run++;
        else if (erase_run > 0) begin erase_lens.push_back(erase_run); erase_run = 0; end
        if (expose) expose_run++;
        else if (expose_run > 0) begin expose_lens.push_back(expose_run); expose_run = 0; end
        if (convert) convert_run++;
        else if (convert_run > 0) begin convert_lens.push_back(convert_run); convert_run = 0; end

        if (convert) begin
            if (adc_count != adc_exp) adc_errs++;
            adc_exp = adc_exp + 8'd1;
        end else begin
            if (adc_count != 8'd0) adc_errs++;
            adc_exp = 8'd0;
        end

        if (frame_done) done_cnt++;
        if (busy && !out_if.out_valid &&
            ($countones(read_row) + int'(erase) + int'(expose) + int'(convert)) != 1)
            overlap_errs++;

        if (out_if.out_valid && out_if.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got %h, required no beat",
                         {out_if.out_row, out_if.out_data});
            end else begin
                mon_exp = exp_q.pop_front();
                if ({out_if.out_row, out_if.out_data} !== mon_exp) begin
                    errors++;
                    $display("FAIL beat_data: got %h, required %h",
                             {out_if.out_row, out_if.out_data}, mon_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic clear_mon();
        erase_lens.delete();
        expose_lens.delete();
        convert_lens.delete();
        exp_q.delete();
        done_cnt     = 0;
        adc_errs     = 0;
        overlap_errs = 0;
    endtask

    task automatic push_frame();
        for (int r = 0; r < ROWS; r++) exp_q.push_back(row_word(r));
    endtask

    task automatic pulse_start(input logic [7:0] exp_in, input logic cont, input logic stp);
        exposure_cycles = exp_in;
        continuous      = cont;
        stop            = stp;
        start           = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int frames);
        int n = 0;
        while (!(done_cnt >= frames && !busy) && n < BUDGET) begin
            step();
            n++;
        end
        if (n == BUDGET) check({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    // Waits on a named DUT strobe; 0 erase, 1 expose, 2 convert, 3 out_valid.
    task automatic wait_sig(input string name, input int which);
        int n = 0;
        logic s;
        s = 1'b0;
        while (n < BUDGET) begin
            case (which)
                0: s = erase;
                1: s = expose;
                2: s = convert;
                default: s = out_if.out_valid;
            endcase
            if (s) break;
            step();
            n++;
        end
        if (n == BUDGET) check({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] exp_in;
        logic       cont;
        logic       stop_with_start;
        int         exp_expose;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [W-1:0] held;
        int stable_errs;
        int gap;
        int n;

        vecs[0] = '{exp_in: 8'd10,  cont: 1'b0, stop_with_start: 1'b0, exp_expose: 10};
        vecs[1] = '{exp_in: 8'd0,   cont: 1'b0, stop_with_start: 1'b0, exp_expose: 1};
        vecs[2] = '{exp_in: 8'd1,   cont: 1'b0, stop_with_start: 1'b0, exp_expose: 1};
        vecs[3] = '{exp_in: 8'd3,   cont: 1'b1, stop_with_start: 1'b1, exp_expose: 3};
        vecs[4] = '{exp_in: 8'd255, cont: 1'b0, stop_with_start: 1'b0, exp_expose: 255};

        out_if.out_ready = 1'b1;

        // Reset state.
        repeat (3) step();
        check("reset_outputs", all_outs(), 64'd0);
        check("reset_state", 64'(dbg_state), 64'({IDLE, RD_IDLE}));
        reset = 1'b1;
        repeat (2) step();
        check("idle_outputs", all_outs(), 64'd0);

        // Table-driven single-frame vectors.
        for (int i = 0; i < 5; i++) begin
            clear_mon();
            push_frame();
            pulse_start(vecs[i].exp_in, vecs[i].cont, vecs[i].stop_with_start);
            wait_idle($sformatf("v%0d", i), 1);
            repeat (20) step();
            check($sformatf("v%0d_erase_count", i), 64'(erase_lens.size()), 64'd1);
            check($sformatf("v%0d_erase_len", i),
                  64'((erase_lens.size() > 0) ? erase_lens[0] : -1), 64'(C_ERASE));
            check($sformatf("v%0d_expose_len", i),
                  64'((expose_lens.size() > 0) ? expose_lens[0] : -1), 64'(vecs[i].exp_expose));
            check($sformatf("v%0d_convert_len", i),
                  64'((convert_lens.size() > 0) ? convert_lens[0] : -1), 64'(C_CONVERT + 1));
            check($sformatf("v%0d_adc_errs", i), 64'(adc_errs), 64'd0);
            check($sformatf("v%0d_overlap", i), 64'(overlap_errs), 64'd0);
            check($sformatf("v%0d_frame_done", i), 64'(done_cnt), 64'd1);
            check($sformatf("v%0d_beats_left", i), 64'(exp_q.size()), 64'd0);
            check($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
        end

        // Back-pressure on row 2.
        clear_mon();
        push_frame();
        pulse_start(8'd2, 1'b0, 1'b0);
        n = 0;
        while (!read_row[2] && n < BUDGET) begin step(); n++; end
        if (n == BUDGET) check("bp_row2_timeout", 64'd1, 64'd0);
        out_if.out_ready = 1'b0;
        wait_sig("bp_valid", 3);
        held = {out_if.out_row, out_if.out_data};
        check("bp_held_row2", 64'(held), 64'(row_word(2)));
        stable_errs = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (!out_if.out_valid || read_row != '0 ||
                {out_if.out_row, out_if.out_data} != held) stable_errs++;
        end
        check("bp_stable", 64'(stable_errs), 64'd0);
        out_if.out_ready = 1'b1;
        step();
        check("bp_after_accept", 64'({out_if.out_valid, read_row}), 64'({1'b0, 4'b1000}));
        gap = 0;
        while (read_row[3] && !out_if.out_valid && gap < 10) begin step(); gap++; end
        check("bp_settle_gap", 64'(gap), 64'(C_SETTLE));
        check("bp_row3_valid", 64'({out_if.out_valid, out_if.out_row}), 64'({1'b1, 2'd3}));
        wait_idle("bp", 1);
        check("bp_frame_done", 64'(done_cnt), 64'd1);
        check("bp_beats_left", 64'(exp_q.size()), 64'd0);

        // Continuous run, exposure changed mid-frame, stop during frame 2.
        clear_mon();
        push_frame();
        push_frame();
        pulse_start(8'd10, 1'b1, 1'b0);
        wait_sig("cont_convert", 2);
        exposure_cycles = 8'd20;
        continuous      = 1'b0;
        n = 0;
        while (done_cnt < 1 && n < BUDGET) begin step(); n++; end
        if (n == BUDGET) check("cont_done1_timeout", 64'd1, 64'd0);
        repeat (3) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle("cont", 2);
        repeat (30) step();
        check("cont_erase_count", 64'(erase_lens.size()), 64'd2);
        check("cont_expose1",
              64'((expose_lens.size() > 0) ? expose_lens[0] : -1), 64'd10);
        check("cont_expose2",
              64'((expose_lens.size() > 1) ? expose_lens[1] : -1), 64'd20);
        check("cont_frame_done", 64'(done_cnt), 64'd2);
        check("cont_beats_left", 64'(exp_q.size()), 64'd0);
        check("cont_overlap", 64'(overlap_errs + adc_errs), 64'd0);

        // start pulsed during CONVERT is ignored.
        clear_mon();
        push_frame();
        pulse_start(8'd4, 1'b0, 1'b0);
        wait_sig("sic_convert", 2);
        repeat (10) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle("sic", 1);
        repeat (20) step();
        check("sic_erase_count", 64'(erase_lens.size()), 64'd1);
        check("sic_expose_len",
              64'((expose_lens.size() > 0) ? expose_lens[0] : -1), 64'd4);
        check("sic_convert_len",
              64'((convert_lens.size() > 0) ? convert_lens[0] : -1), 64'(C_CONVERT + 1));
        check("sic_frame_done", 64'(done_cnt), 64'd1);

        // Reset mid-EXPOSE.
        clear_mon();
        pulse_start(8'd50, 1'b0, 1'b0);
        wait_sig("rst_expose", 1);
        repeat (5) step();
        reset = 1'b0;
        #1;
        check("rst_outputs_now", all_outs(), 64'd0);
        repeat (3) step();
        reset = 1'b1;
        repeat (20) step();
        check("rst_state_idle", 64'(dbg_state), 64'({IDLE, RD_IDLE}));
        check("rst_no_done", 64'(done_cnt), 64'd0);
        check("rst_no_restart", 64'(erase_lens.size()), 64'd1);
        check("rst_outputs_idle", all_outs(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
